// File: rtl/spi_controller.sv
// SPI mode-0 write-only initiator: sends {1'b1, addr[6:0], data[7:0]} MSB first per accepted request.
// All pins (ncs/sclk/copi) and status outputs are flops loaded from the next-state decode.
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    output logic       busy,
    output logic       done
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                   : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state, state_nxt;
    logic [15:0]       sreg, sreg_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [3:0]        bit_cnt, bit_nxt;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;
    logic              ncs_nxt, sclk_nxt, copi_nxt, busy_nxt, done_nxt, ready_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            div       <= '0;
            bit_cnt   <= '0;
            wcnt      <= '0;
            ncs       <= 1'b1;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            div       <= div_nxt;
            bit_cnt   <= bit_nxt;
            wcnt      <= wcnt_nxt;
            ncs       <= ncs_nxt;
            sclk      <= sclk_nxt;
            copi      <= copi_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            req_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        div_nxt   = div;
        bit_nxt   = bit_cnt;
        wcnt_nxt  = wcnt;
        sclk_nxt  = sclk;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    sreg_nxt  = {1'b1, req_addr, req_data};
                    wcnt_nxt  = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (wcnt == SETUP_LAST) begin
                    wcnt_nxt  = '0;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            SHIFT: begin
                // The shift happens together with the falling edge, so copi is frozen while sclk is high.
                if (div == DIV_LAST) begin
                    div_nxt = '0;
                    if (!sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            wcnt_nxt  = '0;
                            state_nxt = HOLD;
                        end else begin
                            bit_nxt  = bit_cnt + 1'b1;
                            sreg_nxt = {sreg[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            HOLD: begin
                if (wcnt == HOLD_LAST) begin
                    wcnt_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            GAP: begin
                if (wcnt == GAP_LAST) begin
                    wcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ncs_nxt   = (state_nxt == IDLE) || (state_nxt == GAP);
        copi_nxt  = ncs_nxt ? 1'b0 : sreg_nxt[15];
        busy_nxt  = (state_nxt != IDLE);
        ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_spi_controller.sv
// Randomized scoreboard bench for spi_controller: two instances (CLK_DIV 4 and 3), a pin-level
// monitor per instance decodes frames and timing and compares them with queued expected words.
module tb_spi_controller;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int BUDGET   = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] valid_v, ready_v, ncs_v, sclk_v, copi_v, busy_v, done_v;
    logic [6:0] addr_v [2];
    logic [7:0] data_v [2];

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    int passed = 0, total = 0;
    int accepts0 = 0, accepts1 = 0, frames0 = 0, frames1 = 0;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(valid_v[0]), .req_ready(ready_v[0]),
        .req_addr(addr_v[0]), .req_data(data_v[0]), .ncs(ncs_v[0]), .sclk(sclk_v[0]),
        .copi(copi_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    spi_controller #(.CLK_DIV(3), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(valid_v[1]), .req_ready(ready_v[1]),
        .req_addr(addr_v[1]), .req_data(data_v[1]), .ncs(ncs_v[1]), .sclk(sclk_v[1]),
        .copi(copi_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    // Pin-level monitor: reconstructs each frame purely from ncs/sclk/copi waveforms.
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int D    = (g == 0) ? 4 : 3;
        localparam int LOWC = CS_SETUP + 32 * D + CS_HOLD;
        initial begin
            logic p_ncs, p_sclk, p_copi, have;
            logic [15:0] word, e;
            int run, rises, lowlen;
            bit phase_bad, copi_bad, ready_bad;
            p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
            word = '0; e = '0; run = 0; rises = 0; lowlen = 0;
            phase_bad = 0; copi_bad = 0; ready_bad = 0; have = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
                    run = 0; rises = 0; lowlen = 0; word = '0;
                    phase_bad = 0; copi_bad = 0; ready_bad = 0;
                end else begin
                    if (done_v[g])
                        chk($sformatf("done_at_ncs_rise[%0d]", g), int'(!p_ncs && ncs_v[g]), 1);
                    if (!ncs_v[g]) begin
                        if (p_ncs) begin
                            run = 1; rises = 0; lowlen = 1; word = '0;
                            phase_bad = 0; copi_bad = 0; ready_bad = 0;
                        end else begin
                            lowlen++;
                            if (sclk_v[g] && copi_v[g] != p_copi) copi_bad = 1;
                            if (sclk_v[g] == p_sclk) begin
                                run++;
                            end else begin
                                if (sclk_v[g]) begin
                                    if (run != ((rises == 0) ? CS_SETUP + D : D)) phase_bad = 1;
                                    rises++;
                                    word = {word[14:0], copi_v[g]};
                                end else if (run != D) begin
                                    phase_bad = 1;
                                end
                                run = 1;
                            end
                        end
                        if (ready_v[g] || !busy_v[g]) ready_bad = 1;
                    end else if (!p_ncs) begin
                        if (g == 0) begin
                            have = (exp_q0.size() > 0);
                            if (have) e = exp_q0.pop_front();
                            frames0++;
                        end else begin
                            have = (exp_q1.size() > 0);
                            if (have) e = exp_q1.pop_front();
                            frames1++;
                        end
                        chk($sformatf("frame_expected[%0d]", g), int'(have), 1);
                        if (have) chk($sformatf("frame_word[%0d]", g), int'(word), int'(e));
                        chk($sformatf("sclk_rises[%0d]", g), rises, 16);
                        chk($sformatf("ncs_low_len[%0d]", g), lowlen, LOWC);
                        chk($sformatf("hold_len[%0d]", g), run, CS_HOLD);
                        chk($sformatf("sclk_phase_len[%0d]", g), int'(phase_bad), 0);
                        chk($sformatf("copi_stable_high[%0d]", g), int'(copi_bad), 0);
                        chk($sformatf("ready_low_in_frame[%0d]", g), int'(ready_bad), 0);
                        chk($sformatf("done_pulse[%0d]", g), int'(done_v[g]), 1);
                        chk($sformatf("sclk_idle_low[%0d]", g), int'(sclk_v[g]), 0);
                    end
                    p_ncs = ncs_v[g]; p_sclk = sclk_v[g]; p_copi = copi_v[g];
                end
            end
        end
    end

    // Issue one request on instance i, queue its expected frame, and time the return of ready.
    task automatic send(input int i, input logic [6:0] a, input logic [7:0] d,
                        input bit hold, input bit junk);
        int t;
        bit bad;
        addr_v[i] = a; data_v[i] = d; valid_v[i] = 1'b1;
        t = 0;
        while (!ready_v[i] && t < BUDGET) begin
            @(posedge clk); #1; t++;
        end
        chk("accept_wait", int'(t < BUDGET), 1);
        if (t >= BUDGET) begin
            valid_v[i] = 1'b0;
            return;
        end
        if (i == 0) begin exp_q0.push_back({1'b1, a, d}); accepts0++; end
        else        begin exp_q1.push_back({1'b1, a, d}); accepts1++; end
        @(posedge clk); #1;
        if (!hold) valid_v[i] = 1'b0;
        chk("accept_ncs_low", int'(ncs_v[i]), 0);
        chk("accept_busy", int'(busy_v[i]), 1);
        chk("accept_ready_low", int'(ready_v[i]), 0);
        chk("accept_copi_bit15", int'(copi_v[i]), 1);
        t = 1; bad = 0;
        while (!ready_v[i] && t < BUDGET) begin
            if (!busy_v[i]) bad = 1;
            if (junk && !hold) begin
                valid_v[i] = (t == 40);
                if (t == 40) begin
                    addr_v[i] = 7'($urandom);
                    data_v[i] = 8'($urandom);
                end
            end
            @(posedge clk); #1; t++;
        end
        chk("accept_to_ready", t, CS_SETUP + 32 * div_of(i) + CS_HOLD + CS_GAP + 1);
        chk("busy_through_frame", int'(bad), 0);
        chk("busy_clear_idle", int'(busy_v[i]), 0);
    endtask

    initial begin
        int t, r, n;
        logic ps;
        rst = 1'b1;
        valid_v = '0;
        addr_v[0] = '0; addr_v[1] = '0; data_v[0] = '0; data_v[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", int'(ncs_v[0]), 1);
        chk("rst_sclk", int'(sclk_v[0]), 0);
        chk("rst_copi", int'(copi_v[0]), 0);
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_ready", int'(ready_v[0]), 1);
        chk("rst_ready_div3", int'(ready_v[1]), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        send(0, 7'h00, 8'hA5, 1'b0, 1'b0);
        send(0, 7'h7F, 8'hFF, 1'b1, 1'b0);
        send(0, 7'h04, 8'h00, 1'b0, 1'b0);
        send(0, 7'($urandom), 8'($urandom), 1'b0, 1'b1);
        send(0, 7'($urandom), 8'($urandom), 1'b0, 1'b1);

        // Abort a frame mid-shift with an asynchronous reset.
        addr_v[0] = 7'h2A; data_v[0] = 8'h5C; valid_v[0] = 1'b1;
        t = 0;
        while (!ready_v[0] && t < BUDGET) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        r = 0; ps = 1'b0; t = 0;
        while (r < 7 && t < BUDGET) begin
            @(posedge clk); #1; t++;
            if (sclk_v[0] && !ps) r++;
            ps = sclk_v[0];
        end
        chk("abort_reach_bit7", r, 7);
        #1 rst = 1'b1;
        #1;
        chk("abort_ncs_high", int'(ncs_v[0]), 1);
        chk("abort_sclk_low", int'(sclk_v[0]), 0);
        chk("abort_busy_low", int'(busy_v[0]), 0);
        chk("abort_ready_high", int'(ready_v[0]), 1);
        chk("abort_no_done", int'(done_v[0]), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        send(0, 7'h12, 8'h34, 1'b0, 1'b0);

        send(1, 7'h00, 8'hA5, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            send(1, 7'($urandom), 8'($urandom), 1'(k < 4 && $urandom_range(0, 1) == 1), 1'b0);
        valid_v[1] = 1'b0;

        for (int k = 0; k < 200; k++) begin
            send(0, 7'($urandom), 8'($urandom), 1'(k < 199 && $urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0));
            if (!valid_v[0]) begin
                n = $urandom_range(0, 3);
                repeat (n) @(posedge clk);
                #1;
            end
        end
        valid_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        chk("frame_count_div4", frames0, accepts0);
        chk("frame_count_div3", frames1, accepts1);
        chk("queue_drained_div4", exp_q0.size(), 0);
        chk("queue_drained_div3", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
